// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bundle layout and default widths.
// Imported by the ID/EX register and the hazard-detection logic.
package mips_pkg;

    localparam int unsigned DW_DEFAULT    = 32;
    localparam int unsigned RW_DEFAULT    = 5;
    localparam int unsigned CNT_W_DEFAULT = 16;

    localparam int unsigned CTRL_W = 9;
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_REG_DST    = 4;
    localparam int unsigned CTRL_ALU_SRC    = 5;
    localparam int unsigned CTRL_ALU_OP_LSB = 6;
    localparam int unsigned CTRL_ALU_OP_MSB = 8;

    // Field order mirrors the bit positions above (first field is the MSB end).
    typedef struct packed {
        logic [2:0] aluOp;
        logic       aluSrc;
        logic       regDst;
        logic       memToReg;
        logic       memWrite;
        logic       memRead;
        logic       regWrite;
    } ctrl_t;

    function automatic logic ctrlIsLoad(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: combinational stall request for PC and IF/ID.
// Kept separate so the check can move to another stage boundary unchanged.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int unsigned RW = RW_DEFAULT
) (
    input  logic          idValid_i,
    input  logic [RW-1:0] idRs_i,
    input  logic [RW-1:0] idRt_i,
    input  logic          exValid_i,
    input  logic          exMemRead_i,
    input  logic [RW-1:0] exRt_i,
    input  logic          flush_i,
    input  logic          memBusy_i,
    output logic          loadUse_o,
    output logic          hzStall_o
);

    logic exRtNonZero;
    logic srcMatch;

    always_comb begin
        exRtNonZero = (exRt_i != '0);
        srcMatch    = (exRt_i == idRs_i) || (exRt_i == idRt_i);
        loadUse_o   = idValid_i && exValid_i && exMemRead_i && exRtNonZero && srcMatch;
        // A flush kills the dependent instruction, so holding it upstream is pointless.
        hzStall_o   = memBusy_i || (loadUse_o && !flush_i);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// memory-stall freeze and a saturating count of inserted bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned RW    = RW_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc4,
    input  logic [DW-1:0]     id_rdata1,
    input  logic [DW-1:0]     id_rdata2,
    input  logic [DW-1:0]     id_imm,
    input  logic [RW-1:0]     id_rs,
    input  logic [RW-1:0]     id_rt,
    input  logic [RW-1:0]     id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              hz_stall,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc4,
    output logic [DW-1:0]     ex_rdata1,
    output logic [DW-1:0]     ex_rdata2,
    output logic [DW-1:0]     ex_imm,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic             exValid_q,  exValid_d;
    logic [DW-1:0]    exPc4_q,    exPc4_d;
    logic [DW-1:0]    exRdata1_q, exRdata1_d;
    logic [DW-1:0]    exRdata2_q, exRdata2_d;
    logic [DW-1:0]    exImm_q,    exImm_d;
    logic [RW-1:0]    exRs_q,     exRs_d;
    logic [RW-1:0]    exRt_q,     exRt_d;
    logic [RW-1:0]    exRd_q,     exRd_d;
    ctrl_t            exCtrl_q,   exCtrl_d;
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;

    logic loadUse;
    logic hzStall;

    hazard_detect #(
        .RW (RW)
    ) u_hazard_detect (
        .idValid_i   (id_valid),
        .idRs_i      (id_rs),
        .idRt_i      (id_rt),
        .exValid_i   (exValid_q),
        .exMemRead_i (ctrlIsLoad(exCtrl_q)),
        .exRt_i      (exRt_q),
        .flush_i     (flush),
        .memBusy_i   (mem_busy),
        .loadUse_o   (loadUse),
        .hzStall_o   (hzStall)
    );

    always_comb begin
        exValid_d   = exValid_q;
        exPc4_d     = exPc4_q;
        exRdata1_d  = exRdata1_q;
        exRdata2_d  = exRdata2_q;
        exImm_d     = exImm_q;
        exRs_d      = exRs_q;
        exRt_d      = exRt_q;
        exRd_d      = exRd_q;
        exCtrl_d    = exCtrl_q;
        bubbleCnt_d = bubbleCnt_q;

        // mem_busy freezes everything, so the defaults above already cover it.
        if (!mem_busy) begin
            if (flush || loadUse) begin
                exValid_d  = 1'b0;
                exPc4_d    = '0;
                exRdata1_d = '0;
                exRdata2_d = '0;
                exImm_d    = '0;
                exRs_d     = '0;
                exRt_d     = '0;
                exRd_d     = '0;
                exCtrl_d   = ctrl_t'(CTRL_NOP);
                if (!flush && (bubbleCnt_q != '1)) begin
                    bubbleCnt_d = bubbleCnt_q + 1'b1;
                end
            end else begin
                exValid_d  = id_valid;
                exPc4_d    = id_pc4;
                exRdata1_d = id_rdata1;
                exRdata2_d = id_rdata2;
                exImm_d    = id_imm;
                exRs_d     = id_rs;
                exRt_d     = id_rt;
                exRd_d     = id_rd;
                exCtrl_d   = id_valid ? ctrl_t'(id_ctrl) : ctrl_t'(CTRL_NOP);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exValid_q   <= 1'b0;
            exPc4_q     <= '0;
            exRdata1_q  <= '0;
            exRdata2_q  <= '0;
            exImm_q     <= '0;
            exRs_q      <= '0;
            exRt_q      <= '0;
            exRd_q      <= '0;
            exCtrl_q    <= ctrl_t'(CTRL_NOP);
            bubbleCnt_q <= '0;
        end else begin
            exValid_q   <= exValid_d;
            exPc4_q     <= exPc4_d;
            exRdata1_q  <= exRdata1_d;
            exRdata2_q  <= exRdata2_d;
            exImm_q     <= exImm_d;
            exRs_q      <= exRs_d;
            exRt_q      <= exRt_d;
            exRd_q      <= exRd_d;
            exCtrl_q    <= exCtrl_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign hz_stall   = hzStall;
    assign ex_valid   = exValid_q;
    assign ex_pc4     = exPc4_q;
    assign ex_rdata1  = exRdata1_q;
    assign ex_rdata2  = exRdata2_q;
    assign ex_imm     = exImm_q;
    assign ex_rs      = exRs_q;
    assign ex_rt      = exRt_q;
    assign ex_rd      = exRd_q;
    assign ex_ctrl    = exCtrl_q;
    assign bubble_cnt = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios plus random traffic
// checked against a cycle-level model of the ID/EX register rules.
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 5;   // narrow so saturation is reachable quickly

    localparam logic [8:0] ADD = 9'h091;
    localparam logic [8:0] LW  = 9'h02B;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc4;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [8:0]    ctrl;
    } stage_t;

    typedef struct packed {
        stage_t           st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [DW-1:0]    id_pc4 = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
    logic [RW-1:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic [8:0]       id_ctrl = '0;
    logic             flush = 1'b0, mem_busy = 1'b0;
    logic             hz_stall, ex_valid;
    logic [DW-1:0]    ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
    logic [RW-1:0]    ex_rs, ex_rt, ex_rd;
    logic [8:0]       ex_ctrl;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc4(id_pc4),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .flush(flush), .mem_busy(mem_busy), .hz_stall(hz_stall),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1),
        .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic hzQ[$];
    exp_t exQ[$];

    stage_t           mSt  = '0;
    logic [CNT_W-1:0] mCnt = '0;
    logic             mHz  = 1'b0;

    function automatic exp_t actual();
        exp_t a;
        a.st = '{valid: ex_valid, pc4: ex_pc4, r1: ex_rdata1, r2: ex_rdata2, imm: ex_imm,
                 rs: ex_rs, rt: ex_rt, rd: ex_rd, ctrl: ex_ctrl};
        a.cnt = bubble_cnt;
        return a;
    endfunction

    function automatic stage_t mkId(input logic v, input logic [RW-1:0] rs,
                                    input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                                    input logic [8:0] ctrl);
        stage_t s;
        s = '{valid: v, pc4: $urandom, r1: $urandom, r2: $urandom, imm: $urandom,
              rs: rs, rt: rt, rd: rd, ctrl: ctrl};
        return s;
    endfunction

    // One clock cycle: drive at the falling edge, predict, enqueue, advance the model.
    task automatic applyCycle(input stage_t id, input bit busy, input bit fl, input bit rstLow);
        bit   lu;
        exp_t e;
        exp_t zero;
        rst       = !rstLow;
        id_valid  = id.valid;  id_pc4 = id.pc4;  id_rdata1 = id.r1;  id_rdata2 = id.r2;
        id_imm    = id.imm;    id_rs  = id.rs;   id_rt     = id.rt;  id_rd     = id.rd;
        id_ctrl   = id.ctrl;   mem_busy = busy;  flush     = fl;
        #1;
        if (rstLow) begin
            zero = '0;
            mSt  = '0;
            mCnt = '0;
            vectors++;
            if (actual() !== zero) begin
                miscompares++;
                $display("FAIL async_reset actual=%h required=%h", actual(), zero);
            end
        end
        lu  = id.valid && mSt.valid && mSt.ctrl[1] && (mSt.rt != 0) &&
              (mSt.rt == id.rs || mSt.rt == id.rt);
        mHz = busy || (lu && !fl);
        hzQ.push_back(mHz);
        if (!rstLow && !busy) begin
            if (fl || lu) begin
                mSt = '0;
                if (!fl && mCnt != {CNT_W{1'b1}}) mCnt = mCnt + 1;
            end else begin
                mSt = id;
                if (!id.valid) mSt.ctrl = '0;
            end
        end
        e.st  = mSt;
        e.cnt = mCnt;
        exQ.push_back(e);
        @(negedge clk);
    endtask

    // Monitors: combinational stall before the edge, registered state after it.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (hzQ.size() > 0) begin
                logic eh;
                eh = hzQ.pop_front();
                vectors++;
                if (hz_stall !== eh) begin
                    miscompares++;
                    $display("FAIL hz_stall t=%0t actual=%b required=%b", $time, hz_stall, eh);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exQ.size() > 0) begin
                exp_t ee;
                ee = exQ.pop_front();
                vectors++;
                if (actual() !== ee) begin
                    miscompares++;
                    $display("FAIL ex_state t=%0t actual=%h required=%h", $time, actual(), ee);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        stage_t id, prevId;
        logic [CNT_W-1:0] allOnes;
        bit busy, fl;
        allOnes = '1;
        @(negedge clk);
        applyCycle(mkId(0, 0, 0, 0, 0), 0, 0, 1);
        // Normal flow, then load-use with one bubble and recovery.
        applyCycle(mkId(1, 3, 4, 5, ADD), 0, 0, 0);
        applyCycle(mkId(1, 1, 8, 0, LW), 0, 0, 0);
        id = mkId(1, 8, 2, 6, ADD);
        applyCycle(id, 0, 0, 0);
        applyCycle(id, 0, 0, 0);
        // Load into $zero never stalls.
        applyCycle(mkId(1, 1, 0, 0, LW), 0, 0, 0);
        applyCycle(mkId(1, 0, 0, 7, ADD), 0, 0, 0);
        // Flush wins over load-use.
        applyCycle(mkId(1, 2, 9, 0, LW), 0, 0, 0);
        applyCycle(mkId(1, 9, 9, 3, ADD), 0, 1, 0);
        // Freeze with a pending hazard and changing ID inputs.
        applyCycle(mkId(1, 2, 10, 0, LW), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyCycle(mkId(1, 10, i[4:0], 4, ADD), 1, 0, 0);
        applyCycle(mkId(1, 11, 12, 4, ADD), 0, 0, 0);
        // Accumulate bubbles, then reset with a live EX instruction.
        for (int i = 0; i < 4; i++) begin
            applyCycle(mkId(1, 1, 8, 0, LW), 0, 0, 0);
            applyCycle(mkId(1, 8, 1, 2, ADD), 0, 0, 0);
        end
        applyCycle(mkId(1, 1, 8, 0, LW), 0, 0, 0);
        applyCycle(mkId(1, 3, 8, 0, ADD), 0, 0, 1);
        // Chained dependent loads until the counter saturates.
        for (int i = 0; i < 80; i++) applyCycle(mkId(1, 8, 8, 0, LW), 0, 0, 0);
        #1;
        vectors++;
        if (bubble_cnt !== allOnes) begin
            miscompares++;
            $display("FAIL saturate actual=%h required=%h", bubble_cnt, allOnes);
        end
        applyCycle(mkId(0, 0, 0, 0, 0), 0, 0, 1);
        // Random traffic; a stalled ID instruction is usually re-presented.
        prevId = '0;
        for (int i = 0; i < 700; i++) begin
            if (mHz && $urandom_range(0, 9) < 8) begin
                id = prevId;
            end else begin
                id = mkId($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom), 9'($urandom));
                id.ctrl[1] = ($urandom_range(0, 9) < 5);
            end
            busy = ($urandom_range(0, 99) < 15);
            fl   = ($urandom_range(0, 99) < 10);
            applyCycle(id, busy, fl, $urandom_range(0, 199) == 0);
            prevId = id;
        end
        applyCycle(mkId(0, 0, 0, 0, 0), 0, 0, 0);
        for (int i = 0; i < 10 && (hzQ.size() > 0 || exQ.size() > 0); i++) @(negedge clk);
        if (hzQ.size() > 0 || exQ.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain actual=%0d pending required=0", hzQ.size() + exQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline, combined with load-use hazard detection.
- Captures decoded operands, register fields and control bits from ID and presents them to EX.
- Its ex_rs/ex_rt outputs are the Rs/Rt source fields consumed by the forwarding unit.
- Inserts a one-cycle bubble on a load-use hazard, squashes on flush, freezes on downstream memory stall, and keeps a saturating bubble counter.

Parameters:
- DW, 32, datapath width (pc4, register data, immediate).
- RW, 5, register-index width.
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc4  in  DW  PC+4 of the ID instruction.
- id_rdata1  in  DW  register-file read data for rs.
- id_rdata2  in  DW  register-file read data for rt.
- id_imm  in  DW  sign-extended immediate.
- id_rs, id_rt, id_rd  in  RW each  instruction register fields.
- id_ctrl  in  9  control bundle (layout in package).
- flush  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- mem_busy  in  1  MEM stage not ready; freeze whole pipeline.
- hz_stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  DW each  registered copies.
- ex_rs, ex_rt, ex_rd  out  RW each  registered fields (to forwarding unit and EX dst mux).
- ex_ctrl  out  9  registered control bundle.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (rst=0, async): every output register is 0, including ex_valid, ex_ctrl and bubble_cnt. hz_stall evaluates with ex_valid=0, so it is 0 unless mem_busy=1. Reset mid-stall discards all state.
- load_use = id_valid & ex_valid & ex_ctrl.memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- hz_stall = mem_busy | (load_use & ~flush). This is combinational, with no register in the path.
- Per-edge priority, highest first:
  1. mem_busy=1: all registers hold, counter holds. flush and load_use are ignored this cycle.
  2. flush=1: bubble into EX (ex_valid=0, ex_ctrl=0, data/field outputs 0). Counter unchanged.
  3. load_use=1: bubble into EX as above; bubble_cnt += 1, saturating at all-ones. ID instruction is held upstream via hz_stall and re-evaluated the next cycle.
  4. Otherwise load: ex_* <= id_*. ex_valid <= id_valid. ex_ctrl <= id_valid ? id_ctrl : 0.
- Latency: one cycle ID to EX. A load followed immediately by a dependent instruction costs exactly one bubble. After the bubble the load is in MEM and the forwarding unit resolves the operand.
- ex_ctrl is all-zero whenever ex_valid=0, so invalid stages never assert regWrite or memWrite.
- $zero destination never triggers a stall (ex_rt == 0 excluded).
- Back-to-back loads with chained dependency each produce one bubble. Consecutive cycles are counted individually.
- bubble_cnt is never cleared except by reset. At saturation it stays at all-ones.

Decomposition:
- Package mips_pkg holds:
  - Control-bundle bit positions: regWrite=0, memRead=1, memWrite=2, memToReg=3, regDst=4, aluSrc=5, aluOp=8:6.
  - CTRL_W=9 and CTRL_NOP=0.
  - DW/RW defaults.
- Sub-module hazard_detect: purely combinational load_use/hz_stall logic, reused if the hazard check moves.
- Registers and counter stay in id_ex_stage.

Test Plan:
- Normal flow: id_valid=1, id_ctrl=add with rs=3, rt=4, rd=5; mem_busy=0, flush=0 -> next cycle ex_rs=3, ex_rt=4, ex_rd=5, ex_valid=1, hz_stall=0.
- Load-use: lw rt=8 in EX, ID add with rs=8 -> hz_stall=1. Next edge: ex_valid=0, ex_ctrl=0, bubble_cnt=1. Following edge: add loads into EX, hz_stall=0.
- $zero load: lw rt=0 in EX, ID rs=0 -> hz_stall=0, no bubble, counter stays 0.
- Flush with load-use: load_use condition true and flush=1 -> hz_stall=0, bubble inserted, bubble_cnt unchanged.
- Freeze: mem_busy=1 for 3 cycles with changing id_* -> ex_* hold their values, hz_stall=1 throughout, counter unchanged. Normal load resumes on release.
- Async reset mid-operation: drop rst between edges while ex_valid=1 and bubble_cnt=5 -> outputs go to 0 immediately, without waiting for a clock edge. Force bubble_cnt to 0xFFFE and trigger 3 bubbles -> it reads 0xFFFF.
